// File: rtl/onewire_master.sv
// onewire_master: slot sequencer for one open-drain 1-Wire line, driving the pad
// cells' tristate output flop and reading their input flop.
// Latency: line low from the cycle after acceptance; response arrives
// 1 + (T_LOW+T_SAMPLE+T_REC)*CLK_DIV cycles after the acceptance cycle.
// Backpressure: cmd_ready only in IDLE; cmd_valid elsewhere is dropped, not queued.
// Optional build macro ONEWIRE_GLITCH_FILTER_EN: 3-stage majority filter on ow_in.
module onewire_master #(
  parameter int CLK_DIV = 29
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  output logic       rsp_valid,
  output logic       rsp_bit,
  output logic       busy,
  output logic       ow_t,
  input  logic       ow_in
);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_DRIVE       = 3'd1,
    S_WAIT_SAMPLE = 3'd2,
    S_RECOVER     = 3'd3,
    S_RESPOND     = 3'd4
  } state_t;

  localparam logic [1:0] OP_RESET  = 2'd0;
  localparam logic [1:0] OP_WRITE0 = 2'd1;
  localparam logic [1:0] OP_WRITE1 = 2'd2;
  localparam logic [1:0] OP_READ   = 2'd3;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t     state_q, state_d;
  logic [1:0] op_q;
  logic [7:0] presc_q, presc_d;
  logic [8:0] us_q, us_d;
  logic       sample_q;
  logic       rsp_bit_q, rsp_bit_d;
  logic       ow_t_q, ow_t_d;

  logic       accept;
  logic       us_tick;
  logic       phase_done;
  logic       line_filt;
  logic [8:0] t_low, t_sample, t_rec, t_cur;

  assign accept  = cmd_valid && cmd_ready;
  assign us_tick = (presc_q == DIV_LAST);

  // Line filtering: optional majority-of-three on the registered pad input.
`ifdef ONEWIRE_GLITCH_FILTER_EN
  logic [2:0] filt_q;

  // Shift the pad input through three stages; idle line level is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_q <= 3'b111;
    end else begin
      filt_q <= {filt_q[1:0], ow_in};
    end
  end

  assign line_filt = (filt_q[0] & filt_q[1]) | (filt_q[1] & filt_q[2]) |
                     (filt_q[0] & filt_q[2]);
`else
  assign line_filt = ow_in;
`endif

  // Slot timing table in microseconds, selected by the latched opcode.
  always_comb begin
    t_low    = 9'd0;
    t_sample = 9'd0;
    t_rec    = 9'd0;
    case (op_q)
      OP_RESET:  begin t_low = 9'd480; t_sample = 9'd70; t_rec = 9'd340; end
      OP_WRITE0: begin t_low = 9'd60;  t_sample = 9'd0;  t_rec = 9'd10;  end
      OP_WRITE1: begin t_low = 9'd6;   t_sample = 9'd0;  t_rec = 9'd64;  end
      default:   begin t_low = 9'd6;   t_sample = 9'd9;  t_rec = 9'd55;  end
    endcase
  end

  // Duration of the phase currently running; a phase ends on the tick that
  // completes its last microsecond.
  always_comb begin
    t_cur = 9'd1;
    case (state_q)
      S_DRIVE:       t_cur = t_low;
      S_WAIT_SAMPLE: t_cur = t_sample;
      S_RECOVER:     t_cur = t_rec;
      default:       t_cur = 9'd1;
    endcase
  end

  assign phase_done = us_tick && (us_q == 9'(t_cur - 9'd1));

  // Next-state logic, counter updates and the result bit for RESPOND.
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    us_d      = us_q;
    rsp_bit_d = rsp_bit_q;

    if (state_q != S_IDLE) begin
      presc_d = us_tick ? 8'd0 : 8'(presc_q + 8'd1);
      if (us_tick) begin
        us_d = 9'(us_q + 9'd1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_DRIVE;
          presc_d = 8'd0;
          us_d    = 9'd0;
        end
      end
      S_DRIVE: begin
        if (phase_done) begin
          state_d = (t_sample == 9'd0) ? S_RECOVER : S_WAIT_SAMPLE;
          us_d    = 9'd0;
        end
      end
      S_WAIT_SAMPLE: begin
        if (phase_done) begin
          state_d = S_RECOVER;
          us_d    = 9'd0;
        end
      end
      S_RECOVER: begin
        if (phase_done) begin
          state_d = S_RESPOND;
          us_d    = 9'd0;
          case (op_q)
            OP_RESET:  rsp_bit_d = ~sample_q;
            OP_WRITE0: rsp_bit_d = 1'b0;
            OP_WRITE1: rsp_bit_d = 1'b1;
            default:   rsp_bit_d = sample_q;
          endcase
        end
      end
      S_RESPOND: begin
        state_d = S_IDLE;
        presc_d = 8'd0;
        us_d    = 9'd0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The pad is only ever pulled low; any state other than DRIVE releases it.
    ow_t_d = (state_d != S_DRIVE);
  end

  // State, counters, latched opcode and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= OP_RESET;
      presc_q   <= 8'd0;
      us_q      <= 9'd0;
      rsp_bit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      us_q      <= us_d;
      rsp_bit_q <= rsp_bit_d;
      if (accept) begin
        op_q <= cmd_op;
      end
    end
  end

  // Sample register: captures the line on the last cycle of WAIT_SAMPLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_q <= 1'b1;
    end else if (state_q == S_WAIT_SAMPLE && phase_done) begin
      sample_q <= line_filt;
    end
  end

  // Tristate control; the async set releases the line immediately on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ow_t_q <= 1'b1;
    end else begin
      ow_t_q <= ow_t_d;
    end
  end

  assign ow_t      = ow_t_q;
  assign cmd_ready = (state_q == S_IDLE) && !reset;
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = (state_q == S_RESPOND);
  assign rsp_bit   = rsp_bit_q;

endmodule

// File: tb/tb_onewire_master.sv
// Self-checking bench for onewire_master with CLK_DIV=4: directed slots from the
// test plan plus randomized slots, checked against a microsecond-level model.
module tb_onewire_master;

  localparam int DIV = 4;

  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic       rsp_valid;
  logic       rsp_bit;
  logic       busy;
  logic       ow_t;
  logic       ow_in;

  int checks = 0;
  int errors = 0;

  onewire_master #(.CLK_DIV(DIV)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .rsp_valid (rsp_valid),
    .rsp_bit   (rsp_bit),
    .busy      (busy),
    .ow_t      (ow_t),
    .ow_in     (ow_in)
  );

  always #5 clk = ~clk;

  // Reference timing table (microseconds), indexed by opcode.
  function automatic int ref_low(input int op);
    int t[4] = '{480, 60, 6, 6};
    return t[op];
  endfunction
  function automatic int ref_sample(input int op);
    int t[4] = '{70, 0, 0, 9};
    return t[op];
  endfunction
  function automatic int ref_rec(input int op);
    int t[4] = '{340, 10, 64, 55};
    return t[op];
  endfunction

  // Device line model: low for cycle offsets [lo, hi) after acceptance.
  function automatic bit line_at(input int n, input int lo, input int hi);
    return !(n >= lo && n < hi);
  endfunction

  // Value the master should act on at its sample cycle.
  function automatic bit ref_sampled(input int op, input int lo, input int hi);
    int ns = (ref_low(op) + ref_sample(op)) * DIV;
`ifdef ONEWIRE_GLITCH_FILTER_EN
    int votes = int'(line_at(ns - 1, lo, hi)) + int'(line_at(ns - 2, lo, hi)) +
                int'(line_at(ns - 3, lo, hi));
    return votes >= 2;
`else
    return line_at(ns, lo, hi);
`endif
  endfunction

  function automatic bit ref_bit(input int op, input int lo, input int hi);
    bit s = ref_sampled(op, lo, hi);
    case (op)
      0:       return !s;
      1:       return 1'b0;
      2:       return 1'b1;
      default: return s;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Runs one command from an IDLE cycle (observed #1 after an edge). Returns
  // in the IDLE cycle after the response, or early at cycle offset abort_at.
  task automatic run_slot(input int op, input bit keep, input int lo, input int hi,
                          input int abort_at);
    int n = 0;
    int first_low = -1;
    int last_low = -1;
    int low_cnt = 0;
    int busy_cnt = 0;
    int rsp_n = -1;
    logic got_bit = 1'bx;
    bit exp_b = ref_bit(op, lo, hi);
    int exp_rsp = 1 + (ref_low(op) + ref_sample(op) + ref_rec(op)) * DIV;

    chk("ready_before_cmd", 32'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_op    = 2'(op);
    ow_in     = line_at(0, lo, hi);
    while (rsp_n < 0 && n < 4000) begin
      @(posedge clk); #1;
      n++;
      if (!keep && n == 1) cmd_valid = 1'b0;
      if (ow_t === 1'b0) begin
        low_cnt++;
        if (first_low < 0) first_low = n;
        last_low = n;
      end
      if (busy === 1'b1) busy_cnt++;
      if (rsp_valid === 1'b1) begin
        rsp_n   = n;
        got_bit = rsp_bit;
      end
      if (n == abort_at) begin
        chk("ow_t_low_before_abort", 32'(ow_t), 0);
        return;
      end
      ow_in = (rsp_n < 0) ? line_at(n, lo, hi) : 1'b1;
    end
    ow_in = 1'b1;
    chk("first_low_cycle", first_low, 1);
    chk("low_width", low_cnt, ref_low(op) * DIV);
    chk("low_contiguous", last_low - first_low + 1, ref_low(op) * DIV);
    chk("rsp_cycle", rsp_n, exp_rsp);
    chk("rsp_bit", 32'(got_bit), 32'(exp_b));
    chk("busy_span", busy_cnt, exp_rsp);
    @(posedge clk); #1;
    chk("ready_after_rsp", 32'(cmd_ready), 1);
    chk("rsp_valid_single", 32'(rsp_valid), 0);
    chk("rsp_bit_held", 32'(rsp_bit), 32'(exp_b));
    chk("busy_idle", 32'(busy), 0);
  endtask

  initial begin
    int rv;
    int op;
    int ns;
    int lo;
    clk = 1'b0;
    reset = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = 2'd0;
    ow_in = 1'b1;

    // Reset state
    #2 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ow_t", 32'(ow_t), 1);
    chk("rst_ready", 32'(cmd_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_bit", 32'(rsp_bit), 0);
    chk("rst_busy", 32'(busy), 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_reset", 32'(cmd_ready), 1);

    // RESET with a device answering presence at 490..600 us
    run_slot(0, 1'b0, 1 + 490 * DIV, 1 + 600 * DIV, -1);
    // RESET with no device
    run_slot(0, 1'b0, 0, 0, -1);
    // WRITE0 then WRITE1 back-to-back, cmd_valid held through the first slot
    run_slot(1, 1'b1, 0, 0, -1);
    run_slot(2, 1'b0, 0, 0, -1);
    // READ with the device holding the line low 6..30 us, then released
    run_slot(3, 1'b0, 1 + 6 * DIV, 1 + 30 * DIV, -1);
    run_slot(3, 1'b0, 0, 0, -1);
    // One-cycle low glitch exactly at the READ sample cycle
    ns = (ref_low(3) + ref_sample(3)) * DIV;
    run_slot(3, 1'b0, ns, ns + 1, -1);

    // Async reset 100 us into a RESET low phase
    run_slot(0, 1'b0, 0, 0, 1 + 100 * DIV);
    reset = 1'b1;
    #1;
    chk("abort_ow_t_released", 32'(ow_t), 1);
    chk("abort_ready_low", 32'(cmd_ready), 0);
    chk("abort_no_rsp", 32'(rsp_valid), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    ow_in = 1'b1;
    rv = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (rsp_valid === 1'b1) rv++;
    end
    chk("abort_rsp_count", rv, 0);
    chk("abort_idle_ready", 32'(cmd_ready), 1);
    chk("abort_idle_ow_t", 32'(ow_t), 1);
    run_slot(0, 1'b0, 1 + 490 * DIV, 1 + 600 * DIV, -1);

    // Randomized slots with line activity near each op's sample point
    for (int i = 0; i < 10; i++) begin
      op = int'($urandom_range(0, 3));
      ns = (ref_low(op) + ref_sample(op)) * DIV;
      lo = ns - int'($urandom_range(0, 8));
      run_slot(op, 1'($urandom_range(0, 1)), lo, lo + int'($urandom_range(1, 10)), -1);
    end
    cmd_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/onewire_master.md
# onewire_master

Sequencer for a single open-drain 1-Wire line (DS2401/DS2433-class devices) built on the Spartan-XL tristate output flip-flop and input flip-flop pad cells. Accepts one command per handshake: reset/presence, write-0, write-1 or read slot. Generates microsecond-accurate low pulses, samples the line at the standard points and returns one result bit per command. Sits between the host register file and the IOB cells of the 1-Wire pad.

## Interface

**Parameters**
- `CLK_DIV`, default 29: clock cycles per microsecond tick; legal range 2..255.

**Ports**
- `clk`, in, 1: the single clock.
- `reset`, in, 1: reset, asynchronous, active-high.
- `cmd_valid`, in, 1: command request.
- `cmd_ready`, out, 1: high only in IDLE.
- `cmd_op`, in, 2: command code.
  - 0 = RESET
  - 1 = WRITE0
  - 2 = WRITE1
  - 3 = READ
- `rsp_valid`, out, 1: one-cycle pulse when a slot completes.
- `rsp_bit`, out, 1: result bit, held until the next `rsp_valid`.
- `busy`, out, 1: high from command acceptance until the `rsp_valid` cycle, inclusive.
- `ow_t`, out, 1: tristate control for the pad output flip-flop (data tied 0).
  - 1 = released
  - 0 = driving low
- `ow_in`, in, 1: pad input, already registered by the pad input flip-flop.

## Operation

- States: IDLE, DRIVE, WAIT_SAMPLE, RECOVER, RESPOND.
- Per-op timings, all in µs, encoded as a 9-bit constant table (T_LOW / T_SAMPLE / T_REC):
  - RESET: 480 / 70 / 340
  - WRITE0: 60 / 0 / 10
  - WRITE1: 6 / 0 / 64
  - READ: 6 / 9 / 55
- IDLE: `cmd_ready`=1, `ow_t`=1.
  - On `cmd_valid`&&`cmd_ready`: latch `cmd_op`, clear the prescaler and the 9-bit µs counter, go to DRIVE.
- DRIVE: `ow_t`=0 for T_LOW µs, then go to WAIT_SAMPLE.
  - If T_SAMPLE=0, go directly to RECOVER instead.
- WAIT_SAMPLE: `ow_t`=1 for T_SAMPLE µs.
  - On its final cycle, capture the filtered line value into the sample register.
  - Then go to RECOVER.
- RECOVER: `ow_t`=1 for T_REC µs, then go to RESPOND.
- RESPOND: lasts one cycle.
  - `rsp_valid`=1.
  - `rsp_bit` set as follows:
    - RESET: 1 = presence detected, i.e. sample was 0.
    - READ: the sampled value.
    - WRITE0: 0.
    - WRITE1: 1.
  - Then return to IDLE.
- Prescaler: counts 0..CLK_DIV-1 and emits `us_tick` on CLK_DIV-1. The µs counter advances on `us_tick` and is cleared on every phase change.
- `cmd_valid` asserted outside IDLE is ignored, with no queuing. `cmd_op` need only be stable in the accepting cycle.
- The line is never driven high. Releasing it means `ow_t`=1.
- Reset values: `ow_t`=1, `cmd_ready`=0 while `reset` is asserted and 1 after, `rsp_valid`=0, `rsp_bit`=0, `busy`=0, state IDLE, counters 0.
  - Asserting `reset` mid-slot releases the line combinationally-registered (async clear of the `ow_t` register to 1).
  - An aborted slot produces no response.

## Timing

- Acceptance at cycle A puts `ow_t`=0 from cycle A+1.
- Low pulse width is exactly T_LOW×CLK_DIV cycles.
- Sample cycle is A+1+(T_LOW+T_SAMPLE)×CLK_DIV−1, measured at the controller's `ow_in` (pad flop latency is external).
- `rsp_valid` occurs at cycle A+1+(T_LOW+T_SAMPLE+T_REC)×CLK_DIV.
- `cmd_ready` returns to 1 the cycle after `rsp_valid`. Back-to-back commands therefore have a one-cycle IDLE gap.
- Worst-case slot (RESET) takes 890 µs + 2 cycles.

## Configuration

- `ONEWIRE_GLITCH_FILTER_EN` defined:
  - `ow_in` passes through a 3-stage shift register.
  - The filtered value is the majority of the three stages.
  - Sampling uses the filtered value, adding 2 cycles of effective input latency. Nominal sample cycles are unchanged.
  - The filter resets to 3'b111.
- Not defined: the sample register captures `ow_in` directly, and no filter registers exist.

## Test plan

- **RESET with device:** `CLK_DIV`=4, RESET, model pulls `ow_in` low from µs 490 to 600 → `ow_t` low for exactly 1920 cycles; `rsp_bit`=1; `rsp_valid` at A+3561.
- **RESET, no device:** `ow_in` held 1 → `rsp_bit`=0, identical timing.
- **Write slots:** WRITE0 then WRITE1 back-to-back → low widths 240 and 24 cycles; `rsp_bit` 0 then 1; one IDLE cycle between slots; `cmd_valid` held high during a slot is not re-accepted.
- **READ:** model holds `ow_in` low µs 6–30, then repeat with line released → `rsp_bit`=0 then 1; sample taken on cycle A+60.
- **Async reset mid-slot:** assert `reset` at µs 100 of RESET's low phase → `ow_t`=1 before the next clock edge, no `rsp_valid`; the next RESET command runs full-length.
- **Glitch filter:** with `ONEWIRE_GLITCH_FILTER_EN`, a 1-cycle low glitch on `ow_in` at the READ sample point → `rsp_bit`=1. Without the macro → `rsp_bit`=0.
